// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, fetch FSM states, reset PC and the NOP word.
// Imported by the fetch stage and its next-PC sub-block.
package mips_pkg;

    localparam logic [5:0] OP_R_TYPE = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory read port between the fetch stage (master) and imem (slave).
// Handshake: req stays high with addr stable until ack; the cycle with req & ack completes the read.
interface instruction_fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection: jump-register (IFETCH_JR_EN), jump, taken branch, else PC+4.
// All arithmetic wraps modulo 2^32.
module next_pc_logic (
    input  logic [31:0] pc_i,
    input  logic        branch_eq_i,
    input  logic        branch_ne_i,
    input  logic        jump_i,
    input  logic        zero_i,
    input  logic [31:0] branch_offset_i,
    input  logic [25:0] jump_target_i,
`ifdef IFETCH_JR_EN
    input  logic        jump_reg_i,
    input  logic [31:0] rs_data_i,
`endif
    output logic [31:0] pc_plus4_o,
    output logic [31:0] next_pc_o,
    output logic        misalign_o
);

    logic branch_taken;

    always_comb begin
        pc_plus4_o   = pc_i + 32'd4;
        branch_taken = (branch_eq_i & zero_i) | (branch_ne_i & ~zero_i);
        next_pc_o    = pc_plus4_o;
        misalign_o   = 1'b0;
`ifdef IFETCH_JR_EN
        if (jump_reg_i) begin
            next_pc_o  = rs_data_i;
            misalign_o = |rs_data_i[1:0];
        end else
`endif
        if (jump_i) begin
            next_pc_o = {pc_plus4_o[31:28], jump_target_i, 2'b00};
        end else if (branch_taken) begin
            next_pc_o = pc_plus4_o + (branch_offset_i << 2);
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: PC, instruction register and IDLE/FETCH/EXEC/HALT sequencing.
// Define IFETCH_JR_EN to add jump-register support with misaligned-target halt.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    instruction_fetch_if.master        imem,
    output logic [31:0]                instr_o,
    output logic [5:0]                 opcode_o,
    output logic                       instr_valid_o,
    output logic [31:0]                pc_o,
    output logic [31:0]                pc_plus4_o,
    input  logic                       stall_i,
    input  logic                       branch_eq_i,
    input  logic                       branch_ne_i,
    input  logic                       jump_i,
    input  logic                       zero_i,
    input  logic [31:0]                branch_offset_i,
    input  logic [25:0]                jump_target_i,
`ifdef IFETCH_JR_EN
    input  logic                       jump_reg_i,
    input  logic [31:0]                rs_data_i,
`endif
    output logic                       misalign_err_o,
    output fetch_state_t               state_o
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         err_q, err_d;
    logic         req_q, req_d;
    logic         valid_q, valid_d;
    logic [31:0]  pc_plus4;
    logic [31:0]  next_pc;
    logic         misalign;

    next_pc_logic u_next_pc (
        .pc_i            (pc_q),
        .branch_eq_i     (branch_eq_i),
        .branch_ne_i     (branch_ne_i),
        .jump_i          (jump_i),
        .zero_i          (zero_i),
        .branch_offset_i (branch_offset_i),
        .jump_target_i   (jump_target_i),
`ifdef IFETCH_JR_EN
        .jump_reg_i      (jump_reg_i),
        .rs_data_i       (rs_data_i),
`endif
        .pc_plus4_o      (pc_plus4),
        .next_pc_o       (next_pc),
        .misalign_o      (misalign)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        err_d   = err_q;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                if (imem.ack) begin
                    instr_d = imem.rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // Flags are only consumed in the final (unstalled) EXEC cycle.
                if (!stall_i) begin
                    if (misalign) begin
                        err_d   = 1'b1;
                        state_d = HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = FETCH;
                    end
                end
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
        // Outputs are registered from the next state so they align with it.
        req_d   = (state_d == FETCH);
        valid_d = (state_d == EXEC);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            err_q   <= err_d;
            req_q   <= req_d;
            valid_q <= valid_d;
        end
    end

    assign imem.req       = req_q;
    assign imem.addr      = pc_q;
    assign instr_o        = instr_q;
    assign opcode_o       = instr_q[31:26];
    assign instr_valid_o  = valid_q;
    assign pc_o           = pc_q;
    assign pc_plus4_o     = pc_plus4;
    assign misalign_err_o = err_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, sequential fetch, branches, jumps,
// stalls, wraparound and mid-fetch reset; jump-register cases when IFETCH_JR_EN is defined.
module tb_instruction_fetch;
  import mips_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] instr_o;
  logic [5:0]  opcode_o;
  logic        instr_valid_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        stall_i;
  logic        branch_eq_i;
  logic        branch_ne_i;
  logic        jump_i;
  logic        zero_i;
  logic [31:0] branch_offset_i;
  logic [25:0] jump_target_i;
`ifdef IFETCH_JR_EN
  logic        jump_reg_i;
  logic [31:0] rs_data_i;
`endif
  logic        misalign_err_o;
  fetch_state_t state_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_pc;

  instruction_fetch_if imem_if ();

  instruction_fetch dut (
    .clk             (clk),
    .reset           (reset),
    .imem            (imem_if),
    .instr_o         (instr_o),
    .opcode_o        (opcode_o),
    .instr_valid_o   (instr_valid_o),
    .pc_o            (pc_o),
    .pc_plus4_o      (pc_plus4_o),
    .stall_i         (stall_i),
    .branch_eq_i     (branch_eq_i),
    .branch_ne_i     (branch_ne_i),
    .jump_i          (jump_i),
    .zero_i          (zero_i),
    .branch_offset_i (branch_offset_i),
    .jump_target_i   (jump_target_i),
`ifdef IFETCH_JR_EN
    .jump_reg_i      (jump_reg_i),
    .rs_data_i       (rs_data_i),
`endif
    .misalign_err_o  (misalign_err_o),
    .state_o         (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_ctrl();
    branch_eq_i     = 1'b0;
    branch_ne_i     = 1'b0;
    jump_i          = 1'b0;
    zero_i          = 1'b0;
    branch_offset_i = 32'h0;
    jump_target_i   = 26'h0;
`ifdef IFETCH_JR_EN
    jump_reg_i      = 1'b0;
    rs_data_i       = 32'h0;
`endif
  endtask

  // Runs one instruction starting from a FETCH cycle. Control inputs must be set by the caller.
  task automatic run_instr(input string tag, input logic [31:0] word, input int lat,
                           input int stalls, input logic [31:0] exp_next);
    logic saved_jump;
    check({tag, "_fetch_state"}, 32'(state_o), 32'(FETCH));
    for (int i = 0; i < lat; i++) begin
      imem_if.ack   = 1'b0;
      imem_if.rdata = 32'hDEAD_BEEF;
      check({tag, "_wait_req"}, 32'(imem_if.req), 32'd1);
      check({tag, "_wait_addr"}, imem_if.addr, exp_pc);
      check({tag, "_wait_valid"}, 32'(instr_valid_o), 32'd0);
      step();
    end
    imem_if.ack   = 1'b1;
    imem_if.rdata = word;
    check({tag, "_ack_addr"}, imem_if.addr, exp_pc);
    step();
    imem_if.ack = 1'b0;
    check({tag, "_valid"}, 32'(instr_valid_o), 32'd1);
    check({tag, "_instr"}, instr_o, word);
    check({tag, "_opcode"}, 32'(opcode_o), 32'(word[31:26]));
    check({tag, "_exec_req"}, 32'(imem_if.req), 32'd0);
    check({tag, "_plus4"}, pc_plus4_o, exp_pc + 32'd4);
    saved_jump = jump_i;
    for (int i = 0; i < stalls; i++) begin
      // Noise during the stall: a spurious ack and a jump flag that drops before the final cycle.
      stall_i       = 1'b1;
      jump_i        = 1'b1;
      imem_if.ack   = 1'b1;
      imem_if.rdata = 32'h1234_5678;
      step();
      check({tag, "_stall_valid"}, 32'(instr_valid_o), 32'd1);
      check({tag, "_stall_pc"}, pc_o, exp_pc);
      check({tag, "_stall_instr"}, instr_o, word);
    end
    stall_i     = 1'b0;
    jump_i      = saved_jump;
    imem_if.ack = 1'b0;
    step();
    check({tag, "_next_pc"}, pc_o, exp_next);
    check({tag, "_next_state"}, 32'(state_o), 32'(FETCH));
    check({tag, "_next_valid"}, 32'(instr_valid_o), 32'd0);
    check({tag, "_next_req"}, 32'(imem_if.req), 32'd1);
    check({tag, "_err"}, 32'(misalign_err_o), 32'd0);
    exp_pc = exp_next;
    clear_ctrl();
  endtask

  initial begin
    reset         = 1'b0;
    stall_i       = 1'b0;
    imem_if.ack   = 1'b0;
    imem_if.rdata = 32'h0;
    clear_ctrl();

    // Reset held 3 cycles.
    for (int i = 0; i < 3; i++) step();
    check("rst_pc", pc_o, 32'h0040_0000);
    check("rst_instr", instr_o, 32'h0);
    check("rst_state", 32'(state_o), 32'(IDLE));
    check("rst_req", 32'(imem_if.req), 32'd0);
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_err", 32'(misalign_err_o), 32'd0);
    reset = 1'b1;
    step();
    check("rel_req", 32'(imem_if.req), 32'd1);
    check("rel_addr", imem_if.addr, 32'h0040_0000);
    check("rel_instr", instr_o, 32'h0);
    exp_pc = 32'h0040_0000;

    // Sequential fetch, ack latency 0 then 3.
    run_instr("seq0", 32'h2008_0001, 0, 0, 32'h0040_0004);
    run_instr("seq1", 32'h2009_0002, 3, 0, 32'h0040_0008);
    run_instr("seq2", 32'h0000_0000, 1, 0, 32'h0040_000C);
    run_instr("seq3", 32'h0000_0000, 0, 0, 32'h0040_0010);

    // Branches at 0x00400010 with offset -2 words.
    branch_eq_i = 1'b1; zero_i = 1'b1; branch_offset_i = 32'hFFFF_FFFE;
    run_instr("beq_t", 32'h1000_FFFE, 0, 0, 32'h0040_000C);
    run_instr("seq4", 32'h0000_0000, 0, 0, 32'h0040_0010);
    branch_ne_i = 1'b1; zero_i = 1'b1; branch_offset_i = 32'hFFFF_FFFE;
    run_instr("bne_nt", 32'h1400_FFFE, 0, 0, 32'h0040_0014);
    jump_i = 1'b1; jump_target_i = 26'h0100004;
    run_instr("j_back", 32'h0810_0004, 0, 0, 32'h0040_0010);
    branch_ne_i = 1'b1; zero_i = 1'b0; branch_offset_i = 32'hFFFF_FFFE;
    run_instr("bne_t", 32'h1400_FFFE, 2, 0, 32'h0040_000C);

    // Jumps at 0x00400020.
    jump_i = 1'b1; jump_target_i = 26'h0100008;
    run_instr("j_20", 32'h0810_0008, 0, 0, 32'h0040_0020);
    jump_i = 1'b1; jump_target_i = 26'h0100010;
    run_instr("j_40", 32'h0810_0010, 0, 0, 32'h0040_0040);
    jump_i = 1'b1; jump_target_i = 26'h0100008;
    run_instr("j_20b", 32'h0810_0008, 0, 0, 32'h0040_0020);
    jump_i = 1'b1; jump_target_i = 26'h0100010;
    branch_eq_i = 1'b1; zero_i = 1'b1; branch_offset_i = 32'hFFFF_FFFE;
    run_instr("j_over_b", 32'h0810_0010, 0, 0, 32'h0040_0040);

    // 4-cycle stall: spurious jump flag during stall must not be taken.
    run_instr("stall", 32'h8C08_0000, 0, 4, 32'h0040_0044);

    // Branch to 0xFFFFFFFC, then PC+4 wraps to 0.
    branch_eq_i = 1'b1; zero_i = 1'b1; branch_offset_i = 32'hFFEF_FFED;
    run_instr("b_top", 32'h1000_FFED, 0, 0, 32'hFFFF_FFFC);
    run_instr("wrap", 32'h0000_0000, 0, 0, 32'h0000_0000);

    // Reset mid-FETCH with a simultaneous ack: request dropped, PC back to reset value.
    imem_if.ack   = 1'b1;
    imem_if.rdata = 32'hCAFE_F00D;
    reset         = 1'b0;
    step();
    imem_if.ack = 1'b0;
    check("mid_rst_req", 32'(imem_if.req), 32'd0);
    check("mid_rst_pc", pc_o, 32'h0040_0000);
    check("mid_rst_instr", instr_o, 32'h0);
    check("mid_rst_state", 32'(state_o), 32'(IDLE));
    reset = 1'b1;
    step();
    check("mid_rst_refetch_addr", imem_if.addr, 32'h0040_0000);
    exp_pc = 32'h0040_0000;

`ifdef IFETCH_JR_EN
    jump_reg_i = 1'b1; rs_data_i = 32'h0040_0100; jump_i = 1'b1; jump_target_i = 26'h0100010;
    run_instr("jr_ok", 32'h0100_0008, 0, 0, 32'h0040_0100);
    jump_reg_i = 1'b1; rs_data_i = 32'h0040_0102;
    imem_if.ack = 1'b1; imem_if.rdata = 32'h0100_0008;
    step();
    imem_if.ack = 1'b0;
    check("jr_bad_valid", 32'(instr_valid_o), 32'd1);
    step();
    check("jr_bad_err", 32'(misalign_err_o), 32'd1);
    check("jr_bad_state", 32'(state_o), 32'(HALT));
    check("jr_bad_pc", pc_o, 32'h0040_0100);
    clear_ctrl();
    imem_if.ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("halt_req", 32'(imem_if.req), 32'd0);
      check("halt_valid", 32'(instr_valid_o), 32'd0);
      check("halt_err", 32'(misalign_err_o), 32'd1);
    end
    imem_if.ack = 1'b0;
    reset = 1'b0;
    step();
    check("halt_rst_err", 32'(misalign_err_o), 32'd0);
    check("halt_rst_pc", pc_o, 32'h0040_0000);
    reset = 1'b1;
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
